// File: rtl/hv_adc_cond.sv
// ADC result conditioning for the HV core: per channel ready synchronisation,
// sample capture, 1/2/4/8-sample box-car averaging and a sticky missing-conversion flag.

module hv_adc_cond_ch #(
    parameter int DW          = 10,
    parameter int TIMEOUT_CYC = 4096,
    parameter int TO_W        = 13
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic [1:0]    i_avg_sel,
    input  logic          i_timeout_clr,
    input  logic [DW-1:0] i_raw_data,
    input  logic          i_raw_ready,
    output logic [DW-1:0] o_data,
    output logic          o_ready,
    output logic          o_timeout
);

    typedef enum logic {
        ST_DIS = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t          state_q, state_d;
    logic            s1_q, s2_q, s3_q;
    logic [1:0]      avg_sel_q;
    logic [DW+2:0]   acc_q, acc_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [DW-1:0]   data_q, data_d;
    logic            ready_q, ready_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            flag_q, flag_d;

    logic            run;
    logic            cap;
    logic            sel_chg;
    logic            last;
    logic            to_set;
    logic [DW+2:0]   sum;

    // Raw ready is an asynchronous level; s3 only serves edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= i_raw_ready;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_DIS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DIS:  if (i_en)  state_d = ST_RUN;
            ST_RUN:  if (!i_en) state_d = ST_DIS;
            default: state_d = ST_DIS;
        endcase
    end

    // A capture landing on the disabling edge must be dropped, hence the i_en term.
    always_comb begin
        run = (state_q == ST_RUN) && i_en;
    end

    assign cap     = s2_q & ~s3_q;
    assign sel_chg = (i_avg_sel != avg_sel_q);
    assign last    = ((cnt_q + 4'd1) == (4'd1 << avg_sel_q));
    assign sum     = acc_q + {3'b000, i_raw_data};

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ready_d = 1'b0;
        if (!run || sel_chg) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (cap) begin
            if (last) begin
                data_d  = DW'(sum >> avg_sel_q);
                ready_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // The flag sets only on the edge the counter reaches its limit, not while saturated.
    always_comb begin
        to_d   = to_q;
        to_set = 1'b0;
        if (!run || cap) begin
            to_d = '0;
        end else if (to_q != TO_MAX) begin
            to_d   = to_q + 1'b1;
            to_set = (to_q == TO_LAST);
        end
        if (to_set) begin
            flag_d = 1'b1;
        end else if (i_timeout_clr) begin
            flag_d = 1'b0;
        end else begin
            flag_d = flag_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            avg_sel_q <= 2'd0;
            acc_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            to_q      <= '0;
            flag_q    <= 1'b0;
        end else begin
            avg_sel_q <= i_avg_sel;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            to_q      <= to_d;
            flag_q    <= flag_d;
        end
    end

    assign o_data    = data_q;
    assign o_ready   = ready_q;
    assign o_timeout = flag_q;

endmodule

module hv_adc_cond #(
    parameter int DW          = 10,
    parameter int TIMEOUT_CYC = 4096,
    parameter int TO_W        = 13
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_adc_en,
    input  logic [1:0]    i_avg_sel,
    input  logic          i_timeout_clr,
    input  logic [DW-1:0] i_adc_raw_data1,
    input  logic          i_adc_raw_ready1,
    input  logic [DW-1:0] i_adc_raw_data2,
    input  logic          i_adc_raw_ready2,
    output logic [DW-1:0] o_adc_data1,
    output logic          o_adc_ready1,
    output logic [DW-1:0] o_adc_data2,
    output logic          o_adc_ready2,
    output logic          o_adc_timeout1,
    output logic          o_adc_timeout2
);

    hv_adc_cond_ch #(.DW(DW), .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)) u_ch1 (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_en          (i_adc_en),
        .i_avg_sel     (i_avg_sel),
        .i_timeout_clr (i_timeout_clr),
        .i_raw_data    (i_adc_raw_data1),
        .i_raw_ready   (i_adc_raw_ready1),
        .o_data        (o_adc_data1),
        .o_ready       (o_adc_ready1),
        .o_timeout     (o_adc_timeout1)
    );

    hv_adc_cond_ch #(.DW(DW), .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)) u_ch2 (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_en          (i_adc_en),
        .i_avg_sel     (i_avg_sel),
        .i_timeout_clr (i_timeout_clr),
        .i_raw_data    (i_adc_raw_data2),
        .i_raw_ready   (i_adc_raw_ready2),
        .o_data        (o_adc_data2),
        .o_ready       (o_adc_ready2),
        .o_timeout     (o_adc_timeout2)
    );

endmodule

// File: tb/tb_hv_adc_cond.sv
// Scoreboard bench for hv_adc_cond: drivers push expected averages, a monitor
// pops them on every ready pulse and also checks that results hold between pulses.

module tb_hv_adc_cond;

    localparam int DW          = 10;
    localparam int TIMEOUT_CYC = 4096;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_adc_en = 1'b0;
    logic [1:0]    i_avg_sel = 2'd0;
    logic          i_timeout_clr = 1'b0;
    logic [DW-1:0] i_adc_raw_data1 = '0;
    logic          i_adc_raw_ready1 = 1'b0;
    logic [DW-1:0] i_adc_raw_data2 = '0;
    logic          i_adc_raw_ready2 = 1'b0;
    logic [DW-1:0] o_adc_data1, o_adc_data2;
    logic          o_adc_ready1, o_adc_ready2;
    logic          o_adc_timeout1, o_adc_timeout2;

    hv_adc_cond #(.DW(DW), .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(13)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_adc_en         (i_adc_en),
        .i_avg_sel        (i_avg_sel),
        .i_timeout_clr    (i_timeout_clr),
        .i_adc_raw_data1  (i_adc_raw_data1),
        .i_adc_raw_ready1 (i_adc_raw_ready1),
        .i_adc_raw_data2  (i_adc_raw_data2),
        .i_adc_raw_ready2 (i_adc_raw_ready2),
        .o_adc_data1      (o_adc_data1),
        .o_adc_ready1     (o_adc_ready1),
        .o_adc_data2      (o_adc_data2),
        .o_adc_ready2     (o_adc_ready2),
        .o_adc_timeout1   (o_adc_timeout1),
        .o_adc_timeout2   (o_adc_timeout2)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int fails  = 0;
    int pulses1 = 0;
    int pulses2 = 0;
    int cur_sel = 0;
    logic [DW-1:0] exp_q1[$];
    logic [DW-1:0] exp_q2[$];
    logic [DW-1:0] pend1[$];
    logic [DW-1:0] pend2[$];
    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] last2 = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Reference: mean of the pending sample list, truncated.
    function automatic logic [DW-1:0] avg_of(input logic [DW-1:0] q[$], input int sel);
        int unsigned sum;
        sum = 0;
        foreach (q[i]) sum += q[i];
        return DW'(sum >> sel);
    endfunction

    task automatic model_sample(input int ch, input logic [DW-1:0] s);
        if (ch == 1) begin
            pend1.push_back(s);
            if (pend1.size() == (1 << cur_sel)) begin
                exp_q1.push_back(avg_of(pend1, cur_sel));
                pend1.delete();
            end
        end else begin
            pend2.push_back(s);
            if (pend2.size() == (1 << cur_sel)) begin
                exp_q2.push_back(avg_of(pend2, cur_sel));
                pend2.delete();
            end
        end
    endtask

    task automatic send(input int ch, input logic [DW-1:0] d, input int gap);
        model_sample(ch, d);
        if (ch == 1) begin
            i_adc_raw_data1  = d;
            i_adc_raw_ready1 = 1'b1;
        end else begin
            i_adc_raw_data2  = d;
            i_adc_raw_ready2 = 1'b1;
        end
        cyc(4);
        if (ch == 1) i_adc_raw_ready1 = 1'b0;
        else         i_adc_raw_ready2 = 1'b0;
        cyc(3 + gap);
    endtask

    task automatic set_sel(input int s);
        if (s != cur_sel) begin
            pend1.delete();
            pend2.delete();
        end
        cur_sel   = s;
        i_avg_sel = 2'(s);
        cyc(2);
    endtask

    always @(negedge i_clk) begin
        if (i_rst) begin
            last1 = '0;
            last2 = '0;
        end else begin
            if (o_adc_ready1) begin
                pulses1++;
                if (exp_q1.size() == 0) begin
                    check("ch1_unexpected_pulse", 32'(o_adc_data1), 32'hffff_ffff);
                end else begin
                    check("ch1_data", 32'(o_adc_data1), 32'(exp_q1.pop_front()));
                end
                last1 = o_adc_data1;
            end else begin
                check("ch1_hold", 32'(o_adc_data1), 32'(last1));
            end
            if (o_adc_ready2) begin
                pulses2++;
                if (exp_q2.size() == 0) begin
                    check("ch2_unexpected_pulse", 32'(o_adc_data2), 32'hffff_ffff);
                end else begin
                    check("ch2_data", 32'(o_adc_data2), 32'(exp_q2.pop_front()));
                end
                last2 = o_adc_data2;
            end else begin
                check("ch2_hold", 32'(o_adc_data2), 32'(last2));
            end
        end
    end

    initial begin
        int p1, p2, n1, n2;

        // Reset state
        cyc(3);
        check("rst_data1", 32'(o_adc_data1), 0);
        check("rst_data2", 32'(o_adc_data2), 0);
        check("rst_ready1", 32'(o_adc_ready1), 0);
        check("rst_ready2", 32'(o_adc_ready2), 0);
        check("rst_to1", 32'(o_adc_timeout1), 0);
        check("rst_to2", 32'(o_adc_timeout2), 0);
        i_rst    = 1'b0;
        i_adc_en = 1'b1;
        cyc(3);

        // Pass-through and latency
        i_adc_raw_data1 = 10'h2A5;
        model_sample(1, 10'h2A5);
        i_adc_raw_ready1 = 1'b1;
        cyc(2);
        check("lat_early", 32'(o_adc_ready1), 0);
        cyc(1);
        check("lat_pulse", 32'(o_adc_ready1), 1);
        check("lat_data", 32'(o_adc_data1), 32'h2A5);
        check("lat_ch2_data", 32'(o_adc_data2), 0);
        check("lat_ch2_ready", 32'(o_adc_ready2), 0);
        cyc(1);
        check("lat_one_cycle", 32'(o_adc_ready1), 0);
        i_adc_raw_ready1 = 1'b0;
        cyc(3);

        // Four-sample average
        set_sel(2);
        p1 = pulses1;
        send(1, 10'd100, 0);
        send(1, 10'd101, 0);
        send(1, 10'd102, 0);
        check("avg4_no_early_pulse", 32'(pulses1 - p1), 0);
        send(1, 10'd104, 0);
        check("avg4_pulses", 32'(pulses1 - p1), 1);
        check("avg4_data", 32'(o_adc_data1), 32'd101);

        // Depth change discards the partial average
        set_sel(3);
        p1 = pulses1;
        send(1, 10'd500, 0);
        send(1, 10'd600, 0);
        send(1, 10'd700, 1);
        set_sel(1);
        check("selchg_no_pulse", 32'(pulses1 - p1), 0);
        send(1, 10'h3FF, 0);
        send(1, 10'h3FD, 0);
        check("selchg_pulses", 32'(pulses1 - p1), 1);
        check("selchg_data", 32'(o_adc_data1), 32'h3FE);

        // Enable drop mid-average
        p1 = pulses1;
        send(1, 10'd7, 0);
        i_adc_en = 1'b0;
        pend1.delete();
        pend2.delete();
        cyc(6);
        check("dis_hold_data", 32'(o_adc_data1), 32'h3FE);
        i_adc_en = 1'b1;
        cyc(2);
        send(1, 10'd10, 0);
        send(1, 10'd20, 0);
        check("reen_pulses", 32'(pulses1 - p1), 1);
        check("reen_data", 32'(o_adc_data1), 32'd15);

        // Randomized traffic on both channels
        for (int r = 0; r < 8; r++) begin
            set_sel(int'($urandom_range(0, 3)));
            n1 = int'($urandom_range(1, 2 << cur_sel));
            n2 = int'($urandom_range(1, 2 << cur_sel));
            fork
                for (int i = 0; i < n1; i++)
                    send(1, DW'($urandom_range(0, 1023)), int'($urandom_range(0, 3)));
                for (int j = 0; j < n2; j++)
                    send(2, DW'($urandom_range(0, 1023)), int'($urandom_range(0, 3)));
            join
            cyc(2);
        end

        // Timeout set, clear, and set winning over clear
        i_adc_en = 1'b0;
        pend1.delete();
        pend2.delete();
        i_timeout_clr = 1'b1;
        cyc(1);
        i_timeout_clr = 1'b0;
        cyc(2);
        i_adc_en = 1'b1;
        cyc(TIMEOUT_CYC);
        check("to1_before", 32'(o_adc_timeout1), 0);
        check("to2_before", 32'(o_adc_timeout2), 0);
        cyc(1);
        check("to1_set", 32'(o_adc_timeout1), 1);
        check("to2_set", 32'(o_adc_timeout2), 1);
        i_timeout_clr = 1'b1;
        cyc(1);
        i_timeout_clr = 1'b0;
        check("to1_clr", 32'(o_adc_timeout1), 0);
        check("to2_clr", 32'(o_adc_timeout2), 0);
        cyc(5);
        check("to1_stays_clr", 32'(o_adc_timeout1), 0);
        i_adc_en = 1'b0;
        cyc(3);
        i_adc_en = 1'b1;
        cyc(TIMEOUT_CYC);
        i_timeout_clr = 1'b1;
        cyc(1);
        i_timeout_clr = 1'b0;
        check("to1_set_wins", 32'(o_adc_timeout1), 1);
        check("to2_set_wins", 32'(o_adc_timeout2), 1);

        // Reset mid-average with raw ready held high
        set_sel(3);
        fork
            send(1, 10'd300, 0);
            send(2, 10'd400, 0);
        join
        i_adc_raw_data1  = 10'd55;
        i_adc_raw_data2  = 10'd66;
        i_adc_raw_ready1 = 1'b1;
        i_adc_raw_ready2 = 1'b1;
        cyc(3);
        i_rst = 1'b1;
        pend1.delete();
        pend2.delete();
        exp_q1.delete();
        exp_q2.delete();
        cyc(1);
        check("mid_rst_data1", 32'(o_adc_data1), 0);
        check("mid_rst_data2", 32'(o_adc_data2), 0);
        check("mid_rst_ready1", 32'(o_adc_ready1), 0);
        check("mid_rst_ready2", 32'(o_adc_ready2), 0);
        check("mid_rst_to1", 32'(o_adc_timeout1), 0);
        check("mid_rst_to2", 32'(o_adc_timeout2), 0);
        i_rst = 1'b0;
        p1 = pulses1;
        p2 = pulses2;
        cyc(20);
        check("post_rst_pulses1", 32'(pulses1 - p1), 0);
        check("post_rst_pulses2", 32'(pulses2 - p2), 0);
        i_adc_raw_ready1 = 1'b0;
        i_adc_raw_ready2 = 1'b0;
        cyc(5);

        check("drain_q1", 32'(exp_q1.size()), 0);
        check("drain_q2", 32'(exp_q2.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/hv_adc_cond.md
Name: hv_adc_cond

Overview:
- Conditions the two raw analog ADC result streams before they reach the HV core's ADC inputs (i_adc_data1/2, i_adc_ready1/2).
- Per channel: synchronizes the asynchronous ADC ready strobe, captures the sample, and box-car averages 1/2/4/8 samples.
- Emits the averaged 10-bit result with a one-cycle ready pulse.
- Flags a missing-conversion timeout per channel.
- Sits between the analog ADC macros and hv_core, inside the HV wrapper.

Parameters:
- DW, 10, ADC sample width.
- TIMEOUT_CYC, 4096, cycles without a capture event before the timeout flag sets.
- TO_W, 13, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- i_clk  in  1  block clock.
- i_rst  in  1  synchronous active-high reset.
- i_adc_en  in  1  conditioning enable (both channels).
- i_avg_sel  in  2  averaging depth: 0=1, 1=2, 2=4, 3=8 samples.
- i_timeout_clr  in  1  clears both sticky timeout flags.
- i_adc_raw_data1  in  DW  raw ADC1 sample; stable while i_adc_raw_ready1 high.
- i_adc_raw_ready1  in  1  raw ADC1 conversion-done level, asynchronous.
- i_adc_raw_data2  in  DW  raw ADC2 sample.
- i_adc_raw_ready2  in  1  raw ADC2 conversion-done level, asynchronous.
- o_adc_data1  out  DW  averaged ADC1 result, held between updates.
- o_adc_ready1  out  1  one-cycle pulse: new o_adc_data1 valid.
- o_adc_data2  out  DW  averaged ADC2 result.
- o_adc_ready2  out  1  one-cycle pulse: new o_adc_data2 valid.
- o_adc_timeout1  out  1  sticky ADC1 timeout flag.
- o_adc_timeout2  out  1  sticky ADC2 timeout flag.

Behaviour:
- Clocking and reset:
  - Single clock i_clk.
  - i_rst is synchronous, active-high, and has priority over all other inputs.
- Reset values: o_adc_data* = 0, o_adc_ready* = 0, o_adc_timeout* = 0; synchronizers, accumulators, sample counters and timeout counters = 0; FSM = DIS.
- Channels are identical and independent; the description below is per channel.
- Synchronizer and capture:
  - i_adc_raw_ready passes through a 2-flop synchronizer (s1, s2) plus a history flop s3.
  - Capture event = s2 & ~s3.
  - Raw data is sampled on the capture event; it is guaranteed stable, since ready has been high for at least 2 cycles.
- Latency: first i_clk edge sampling ready high = E0. With the averaging count completing, o_adc_ready is high in the cycle following E2 (3 edges). Exactly one pulse per completed average.
- FSM states:
  - DIS: entered when i_adc_en=0.
  - RUN: entered on the edge where i_adc_en is sampled 1.
- DIS:
  - Accumulator, sample count and timeout counter are held at 0.
  - Capture events are ignored.
  - o_adc_ready = 0; o_adc_data holds its last value.
  - o_adc_timeout holds (still clearable).
- RUN, on each capture event:
  - acc += sample (acc width DW+3, no overflow possible); count += 1.
  - When count reaches 2^i_avg_sel:
    - o_adc_data <= (acc + sample) >> i_avg_sel, truncating.
    - o_adc_ready pulses.
    - acc and count reset to 0.
  - i_avg_sel=0 therefore passes each sample straight through.
- i_avg_sel change in RUN:
  - i_avg_sel is registered.
  - Any change clears acc and count on the following edge without producing output.
  - A capture event in that same cycle is discarded.
- Timeout:
  - In RUN, the counter increments each cycle and saturates at TIMEOUT_CYC.
  - It clears to 0 on every capture event.
  - On the edge it reaches TIMEOUT_CYC, o_adc_timeout <= 1.
- i_timeout_clr:
  - Clears both flags.
  - If a set condition occurs in the same cycle, set wins.
  - Does not reset the counters.
- Enable drop mid-average: partial accumulation is discarded and no ready pulse is issued. A capture event coincident with the disable edge is ignored.
- Ready held high indefinitely produces only one capture event; a new event needs ready low for at least 2 cycles.

Test Plan:
1. Reset, en=1, avg_sel=0, ADC1 data=0x2A5, ready high 4 cycles -> o_adc_ready1 pulses once, 3 edges after ready is first sampled; o_adc_data1=0x2A5; channel 2 outputs unchanged at 0.
2. avg_sel=2, ADC1 samples 100,101,102,104 -> single pulse after the 4th capture, o_adc_data1=101 (407>>2); no pulses after samples 1-3.
3. avg_sel=3, 3 samples captured, then avg_sel->1, then 2 samples 0x3FF,0x3FD -> no pulse at the change; next pulse gives 0x3FE.
4. TIMEOUT_CYC=4096, en=1, no ADC2 ready -> o_adc_timeout2 rises at cycle 4096 after enable, o_adc_timeout1 likewise; i_timeout_clr pulse alone clears both; clr coincident with a set cycle leaves the flag at 1.
5. avg_sel=1, one sample captured, en->0 then en->1, then 2 samples 10,20 -> only one pulse, data=15; o_adc_data1 holds its prior value throughout disable.
6. i_rst asserted mid-average with ready high -> all outputs 0 on the next edge; no spurious ready pulse after release while raw ready stays high.
